// File: rtl/alu_pkg.sv
// Shared types for the serial ALU core and its upstream sequencer.
// Op codes, sequencer states, request bundle and byte counts.
package alu_pkg;

  localparam int OPERAND_BYTES = 3;
  localparam int RESULT_BYTES  = 2;

  typedef enum logic [1:0] {
    OP_ADD      = 2'b00,
    OP_SUB      = 2'b01,
    OP_MUL_R4   = 2'b10,
    OP_DIV_SRT2 = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD_A,
    S_LOAD_Q,
    S_LOAD_M,
    S_WAIT,
    S_READ_LO,
    S_RESP
  } seq_state_e;

  // bytes[2]=A, bytes[1]=Q, bytes[0]=M, in core load order
  typedef struct packed {
    op_e                             op;
    logic [OPERAND_BYTES-1:0][7:0]   bytes;
  } req_t;

endpackage

// File: rtl/alu_seq_watchdog.sv
// WAIT-state watchdog for the ALU sequencer.
// Clear on WAIT entry, count WAIT cycles, flag the LIMIT-th one.
module alu_seq_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  // expiry fires on the cycle the last allowed WAIT cycle is spent
  assign expired = en && (cnt_q == CW'(LIMIT - 1));

  // cycle counter, cleared ahead of each WAIT entry
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request/response front end for the byte-serial ALU core.
// Optional WAIT watchdog: define ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_opa,
  input  logic [7:0]  req_opb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        BEGIN,
  output logic [1:0]  op_code,
  output logic [7:0]  inbus,
  input  logic [7:0]  outbus,
  input  logic        END,
  output logic        alu_reset
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  seq_state_e                     state_q;
  req_t                           req_q;
  logic                           rdy_q;
  logic                           busy_q;
  logic                           begin_q;
  logic                           valid_q;
  logic [7:0]                     inbus_q;
  logic [7:0]                     hi_q;
  logic [RESULT_BYTES*8-1:0]      rsp_q;
  logic                           timeout;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic err_q;
  logic abort_q;

  alu_seq_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q == S_LOAD_M),
    .en      (state_q == S_WAIT),
    .expired (timeout)
  );

  assign rsp_err   = err_q;
  assign alu_reset = reset | abort_q;
`else
  assign timeout   = 1'b0;
  assign rsp_err   = 1'b0;
  assign alu_reset = reset;
`endif

  assign req_ready = rdy_q & ~reset;
  assign rsp_valid = valid_q;
  assign rsp_data  = rsp_q;
  assign busy      = busy_q;
  assign BEGIN     = begin_q;
  assign op_code   = req_q.op;
  assign inbus     = inbus_q;

  // sequencer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      begin_q <= 1'b0;
      valid_q <= 1'b0;
      inbus_q <= 8'h00;
      hi_q    <= 8'h00;
      rsp_q   <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      err_q   <= 1'b0;
      abort_q <= 1'b0;
`endif
    end else begin
      begin_q <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      abort_q <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && rdy_q) begin
            req_q.op    <= op_e'(req_op);
            req_q.bytes <= {req_opa, req_opb};
            rdy_q       <= 1'b0;
            busy_q      <= 1'b1;
            begin_q     <= 1'b1;
            state_q     <= S_START;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        S_START: begin
          inbus_q <= req_q.bytes[2];
          state_q <= S_LOAD_A;
        end
        S_LOAD_A: begin
          inbus_q <= req_q.bytes[1];
          state_q <= S_LOAD_Q;
        end
        S_LOAD_Q: begin
          inbus_q <= req_q.bytes[0];
          state_q <= S_LOAD_M;
        end
        S_LOAD_M: begin
          inbus_q <= 8'h00;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (END) begin
            hi_q    <= outbus;
            state_q <= S_READ_LO;
          end else if (timeout) begin
            rsp_q   <= '0;
            valid_q <= 1'b1;
`ifdef ALU_SEQ_TIMEOUT_EN
            err_q   <= 1'b1;
            abort_q <= 1'b1;
`endif
            state_q <= S_RESP;
          end
        end
        S_READ_LO: begin
          rsp_q   <= {hi_q, outbus};
          valid_q <= 1'b1;
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b1;
            req_q.op <= OP_ADD;
            rsp_q    <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a hand-driven core model.
// Watchdog steps run only when ALU_SEQ_TIMEOUT_EN is defined.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_opa;
  logic [7:0]  req_opb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        BEGIN;
  logic [1:0]  op_code;
  logic [7:0]  inbus;
  logic [7:0]  outbus;
  logic        END;
  logic        alu_reset;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_opa   (req_opa),
    .req_opb   (req_opb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .BEGIN     (BEGIN),
    .op_code   (op_code),
    .inbus     (inbus),
    .outbus    (outbus),
    .END       (END),
    .alu_reset (alu_reset)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation; inputs change and outputs are sampled at negedge.
  task automatic run_op(input logic [1:0] op, input logic [15:0] opa,
                        input logic [7:0] opb, input int k,
                        input logic [7:0] hi, input logic [7:0] lo,
                        input int bp, input bit spur);
    logic [15:0] exp;
    exp = {hi, lo};
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_opa   = opa;
    req_opb   = opb;
    @(negedge clk);
    req_valid = 1'b0;
    chk("start_begin", BEGIN, 1);
    chk("start_busy", busy, 1);
    chk("start_opcode", op_code, op);
    chk("start_req_ready", req_ready, 0);
    chk("start_inbus", inbus, 0);
    @(negedge clk);
    chk("load_a_inbus", inbus, opa[15:8]);
    chk("load_a_begin", BEGIN, 0);
    chk("load_a_opcode", op_code, op);
    @(negedge clk);
    chk("load_q_inbus", inbus, opa[7:0]);
    if (spur) begin
      END    = 1'b1;
      outbus = 8'hEE;
    end
    @(negedge clk);
    END    = 1'b0;
    outbus = 8'h00;
    chk("load_m_inbus", inbus, opb);
    chk("load_m_begin", BEGIN, 0);
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      chk("wait_inbus", inbus, 0);
      chk("wait_rsp_valid", rsp_valid, 0);
      chk("wait_opcode", op_code, op);
      if (i == k) begin
        END    = 1'b1;
        outbus = hi;
      end
    end
    @(negedge clk);
    END    = 1'b0;
    outbus = lo;
    chk("read_lo_rsp_valid", rsp_valid, 0);
    chk("read_lo_opcode", op_code, op);
    @(negedge clk);
    outbus = 8'h00;
    chk("resp_valid", rsp_valid, 1);
    chk("resp_data", rsp_data, exp);
    chk("resp_err", rsp_err, 0);
    chk("resp_opcode", op_code, op);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, exp);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_req_ready", req_ready, 1);
    chk("done_opcode", op_code, 0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_opa   = 16'h0000;
    req_opb   = 8'h00;
    rsp_ready = 1'b0;
    outbus    = 8'h00;
    END       = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_alu_reset", alu_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_begin", BEGIN, 0);
    chk("rst_opcode", op_code, 0);
    chk("rst_inbus", inbus, 0);
    reset = 1'b0;
    #1;
    chk("rel_req_ready", req_ready, 0);
    chk("rel_alu_reset", alu_reset, 0);

    // multiply 7*5, k=1
    run_op(2'b10, 16'h0007, 8'h05, 1, 8'h00, 8'h23, 0, 1'b0);
    // divide 100/7 -> rem 2, quo 14, k=4
    run_op(2'b11, 16'h0064, 8'h07, 4, 8'h02, 8'h0E, 0, 1'b0);
    // backpressure: rsp_ready low 10 cycles beyond first RESP cycle
    run_op(2'b00, 16'hA15C, 8'h3B, 2, 8'h00, 8'h97, 10, 1'b0);
    // spurious END during LOAD_Q, real END in WAIT
    run_op(2'b01, 16'h0050, 8'h11, 3, 8'h00, 8'h3F, 0, 1'b1);

    // reset during WAIT
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_opa   = 16'h00FF;
    req_opb   = 8'h02;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_alu_reset", alu_reset, 1);
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_req_ready", req_ready, 0);
    chk("mid_begin", BEGIN, 0);
    chk("mid_opcode", op_code, 0);
    chk("mid_inbus", inbus, 0);
    chk("mid_rsp_data", rsp_data, 0);
    chk("mid_rsp_err", rsp_err, 0);
    chk("mid_alu_reset_hold", alu_reset, 1);
    reset = 1'b0;
    END   = 1'b1;
    outbus = 8'h55;
    @(negedge clk);
    END    = 1'b0;
    outbus = 8'h00;
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_busy", busy, 0);

`ifdef ALU_SEQ_TIMEOUT_EN
    // watchdog: END never comes, limit 8 WAIT cycles
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_opa   = 16'h1234;
    req_opb   = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("wd_wait_alu_reset", alu_reset, 0);
      chk("wd_wait_rsp_valid", rsp_valid, 0);
    end
    @(negedge clk);
    chk("wd_abort_pulse", alu_reset, 1);
    chk("wd_rsp_valid", rsp_valid, 1);
    chk("wd_rsp_err", rsp_err, 1);
    chk("wd_rsp_data", rsp_data, 16'h0000);
    @(negedge clk);
    chk("wd_pulse_end", alu_reset, 0);
    chk("wd_rsp_err_hold", rsp_err, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("wd_done_valid", rsp_valid, 0);
    chk("wd_done_err", rsp_err, 0);
    chk("wd_done_req_ready", req_ready, 1);
    // normal op still works after an abort
    run_op(2'b00, 16'h0001, 8'h01, 2, 8'h00, 8'h02, 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
